// File: rtl/mdio_pkg.sv
// Shared encodings, frame field sizes and FSM state type for the MDIO
// Clause 22 / Clause 45 management master.
package mdio_pkg;

    localparam logic [1:0] OP_C22_WR    = 2'b01;
    localparam logic [1:0] OP_C22_RD    = 2'b10;
    localparam logic [1:0] OP_C45_ADDR  = 2'b00;
    localparam logic [1:0] OP_C45_WR    = 2'b01;
    localparam logic [1:0] OP_C45_RD    = 2'b11;
    localparam logic [1:0] OP_C45_RDINC = 2'b10;

    localparam logic [1:0] ST_C22 = 2'b01;
    localparam logic [1:0] ST_C45 = 2'b00;

    localparam int HDR_BITS  = 14;
    localparam int TA_BITS   = 2;
    localparam int DATA_BITS = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } mdio_state_e;

    // Every read-type OP (C22 read, C45 read, C45 read-increment) has OP[1] set.
    function automatic logic is_read_op(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdio_bit_tick.sv
// MDC divider: one bit period is 2*CLK_DIV clks, MDC low for the first half.
// fall_stb_o / rise_stb_o are high on the clk that drives MDC low / high.
module mdio_bit_tick #(
    parameter int CLK_DIV = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic fall_stb_o,
    output logic rise_stb_o,
    output logic mdc_o
);

    localparam logic [6:0] HALF = 7'(CLK_DIV);
    localparam logic [6:0] LAST = 7'(2 * CLK_DIV - 1);

    logic [6:0] cnt_q, cnt_d;
    logic       mdc_q, mdc_d;

    assign fall_stb_o = en_i && !clr_i && (cnt_q == 7'd0);
    assign rise_stb_o = en_i && !clr_i && (cnt_q == HALF);
    assign mdc_o      = mdc_q;

    always_comb begin
        cnt_d = cnt_q;
        mdc_d = mdc_q;
        if (clr_i) begin
            cnt_d = 7'd0;
            mdc_d = 1'b0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? 7'd0 : cnt_q + 7'd1;
            if (fall_stb_o) mdc_d = 1'b0;
            if (rise_stb_o) mdc_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 7'd0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

endmodule

// File: rtl/mdio_master_c45.sv
// MDIO management master for Clause 22 and Clause 45 frames with a
// valid/ready command port, a one-pulse response port and split pad signals.
module mdio_master_c45
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 5,
    parameter int PRE_LEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_c45,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_phy,
    input  logic [4:0]  cmd_reg,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam int         PRE_LAST_I = (PRE_LEN > 0) ? PRE_LEN - 1 : 0;
    localparam logic [5:0] PRE_LAST   = 6'(PRE_LAST_I);
    localparam logic [5:0] HDR_LAST   = 6'(HDR_BITS - 1);
    localparam logic [5:0] TA_LAST    = 6'(TA_BITS - 1);
    localparam logic [5:0] DATA_END   = 6'(DATA_BITS);
    localparam logic [3:0] HDR_TOP    = 4'(HDR_BITS - 1);
    localparam logic [3:0] DATA_TOP   = 4'(DATA_BITS - 1);

    mdio_state_e state_q, state_d;
    logic [5:0]  bit_q, bit_d;

    logic        c45_q;
    logic [1:0]  op_q;
    logic [4:0]  phy_q;
    logic [4:0]  reg_q;
    logic [15:0] data_q;

    logic [15:0] rd_shift_q;
    logic        ta_err_q;
    logic [15:0] rsp_data_q;
    logic        rsp_err_q;
    logic        mdio_o_q;
    logic        mdio_oe_q;

    logic        fall_stb, rise_stb;
    logic        tick_en;
    logic        drv_o, drv_oe;
    logic        is_rd;
    logic [13:0] hdr_word;

    assign tick_en  = (state_q == S_PRE) || (state_q == S_HDR) ||
                      (state_q == S_TA)  || (state_q == S_DATA);
    assign is_rd    = is_read_op(op_q);
    assign hdr_word = {(c45_q ? ST_C45 : ST_C22), op_q, phy_q, reg_q};

    mdio_bit_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (tick_en),
        .clr_i      (!tick_en),
        .fall_stb_o (fall_stb),
        .rise_stb_o (rise_stb),
        .mdc_o      (mdc)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // DATA is left on the fall after the last bit so MDC completes its high half.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (cmd_valid) state_d = (PRE_LEN == 0) ? S_HDR : S_PRE;
            S_PRE:  if (rise_stb && bit_q == PRE_LAST) state_d = S_HDR;
            S_HDR:  if (rise_stb && bit_q == HDR_LAST) state_d = S_TA;
            S_TA:   if (rise_stb && bit_q == TA_LAST)  state_d = S_DATA;
            S_DATA: if (fall_stb && bit_q == DATA_END) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bit_d = bit_q;
        if (state_d != state_q) bit_d = 6'd0;
        else if (rise_stb)      bit_d = bit_q + 6'd1;
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        rsp_valid = (state_q == S_DONE);
        drv_o     = 1'b1;
        drv_oe    = 1'b0;
        case (state_q)
            S_PRE: begin
                drv_o  = 1'b1;
                drv_oe = 1'b1;
            end
            S_HDR: begin
                drv_o  = hdr_word[HDR_TOP - bit_q[3:0]];
                drv_oe = 1'b1;
            end
            S_TA: begin
                drv_o  = is_rd ? 1'b1 : (bit_q == 6'd0);
                drv_oe = !is_rd;
            end
            S_DATA: begin
                if (bit_q != DATA_END && !is_rd) begin
                    drv_o  = data_q[DATA_TOP - bit_q[3:0]];
                    drv_oe = 1'b1;
                end
            end
            default: begin
                drv_o  = 1'b1;
                drv_oe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_q      <= 6'd0;
            c45_q      <= 1'b0;
            op_q       <= 2'b00;
            phy_q      <= 5'd0;
            reg_q      <= 5'd0;
            data_q     <= 16'h0000;
            rd_shift_q <= 16'h0000;
            ta_err_q   <= 1'b0;
            rsp_data_q <= 16'h0000;
            rsp_err_q  <= 1'b0;
            mdio_o_q   <= 1'b1;
            mdio_oe_q  <= 1'b0;
        end else begin
            bit_q <= bit_d;
            if (cmd_valid && cmd_ready) begin
                c45_q  <= cmd_c45;
                op_q   <= cmd_op;
                phy_q  <= cmd_phy;
                reg_q  <= cmd_reg;
                data_q <= cmd_data;
            end
            // A PHY that answers pulls the second TA bit low.
            if (rise_stb && state_q == S_TA && bit_q == TA_LAST)
                ta_err_q <= mdio_i;
            if (rise_stb && state_q == S_DATA)
                rd_shift_q <= {rd_shift_q[14:0], mdio_i};
            if (state_q == S_DATA && state_d == S_DONE) begin
                rsp_data_q <= is_rd ? rd_shift_q : 16'h0000;
                rsp_err_q  <= is_rd ? ta_err_q : 1'b0;
            end
            if (fall_stb) begin
                mdio_o_q  <= drv_o;
                mdio_oe_q <= drv_oe;
            end
        end
    end

    assign mdio_o   = mdio_o_q;
    assign mdio_oe  = mdio_oe_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule
